// File: rtl/fp_max_finder_pkg.sv
// Shared types and constants for the 13-bit float max-finder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fp_max_finder_pkg;

  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;
  localparam int FP_W   = 1 + EXP_W + FRAC_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

endpackage

// File: rtl/fp_gtr.sv
// Strict greater-than between two sign/exp/frac floats; +0 and -0 compare equal.
// Latency: purely combinational, 0 cycles.
// Backpressure: none, no handshake.
module fp_gtr
  import fp_max_finder_pkg::*;
(
  input  logic              iSign1,
  input  logic [EXP_W-1:0]  iExp1,
  input  logic [FRAC_W-1:0] iFrac1,
  input  logic              iSign2,
  input  logic [EXP_W-1:0]  iExp2,
  input  logic [FRAC_W-1:0] iFrac2,
  output logic              oGtr
);

  logic                    zero1;
  logic                    zero2;
  logic [EXP_W+FRAC_W-1:0] mag1;
  logic [EXP_W+FRAC_W-1:0] mag2;

  // Fractions are normalized, so a zero fraction means the value is zero
  // regardless of exponent; its magnitude is forced to 0 so it sorts lowest.
  always_comb begin
    zero1 = (iFrac1 == '0);
    zero2 = (iFrac2 == '0);
    mag1  = zero1 ? '0 : {iExp1, iFrac1};
    mag2  = zero2 ? '0 : {iExp2, iFrac2};
    oGtr  = 1'b0;
    if (zero1 && zero2) begin
      oGtr = 1'b0;
    end else if (iSign1 != iSign2) begin
      oGtr = !iSign1;
    end else if (!iSign1) begin
      oGtr = (mag1 > mag2);
    end else begin
      oGtr = (mag1 < mag2);
    end
  end

endmodule

// File: rtl/fp_max_finder.sv
// Streaming frame reduction: running max, its index and element count per frame.
// Latency: result valid the cycle after the last element is accepted.
// Backpressure: oReady low while a result waits for iReady; 1 idle cycle between frames.
module fp_max_finder
  import fp_max_finder_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iLast,
  input  logic              iSign,
  input  logic [EXP_W-1:0]  iExp,
  input  logic [FRAC_W-1:0] iFrac,
  output logic              oValid,
  input  logic              iReady,
  output logic              oSign,
  output logic [EXP_W-1:0]  oExp,
  output logic [FRAC_W-1:0] oFrac,
  output logic [IDX_W-1:0]  oIdx,
  output logic [IDX_W-1:0]  oCount,
  output logic              oOvf
);

  state_t            state;
  state_t            state_nxt;
  fp_t               in_el;
  fp_t               max_q;
  fp_t               max_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_nxt;
  logic [IDX_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  cnt_nxt;
  logic              ovf_q;
  logic              ovf_nxt;
  logic              accept;
  logic              gtr;

  assign in_el  = {iSign, iExp, iFrac};
  assign oReady = (state != S_DONE);
  assign oValid = (state == S_DONE);
  assign accept = iValid && oReady;

  // Incoming element is compared directly against the running max register.
  fp_gtr u_gtr (
    .iSign1 (in_el.sign),
    .iExp1  (in_el.exp),
    .iFrac1 (in_el.frac),
    .iSign2 (max_q.sign),
    .iExp2  (max_q.exp),
    .iFrac2 (max_q.frac),
    .oGtr   (gtr)
  );

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: frame start/accumulate until iLast, then hold result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = iLast ? S_DONE : S_ACCUM;
      S_ACCUM: if (accept && iLast) state_nxt = S_DONE;
      S_DONE:  if (iReady) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Running values after accepting the current element; ties keep the
  // earlier element because only a strict greater-than updates the max.
  always_comb begin
    max_nxt = max_q;
    idx_nxt = idx_q;
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    if (state == S_IDLE) begin
      max_nxt = in_el;
      idx_nxt = '0;
      cnt_nxt = IDX_W'(1);
      ovf_nxt = 1'b0;
    end else begin
      if (gtr) begin
        max_nxt = in_el;
        idx_nxt = cnt_q;
      end
      if (&cnt_q) begin
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_q + IDX_W'(1);
      end
    end
  end

  // Running max/index/count registers, updated on every accepted element.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      max_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      max_q <= max_nxt;
      idx_q <= idx_nxt;
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  // Result registers: captured with the last element so they stay frozen
  // through DONE and keep the previous frame's result afterwards.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oSign  <= 1'b0;
      oExp   <= '0;
      oFrac  <= '0;
      oIdx   <= '0;
      oCount <= '0;
      oOvf   <= 1'b0;
    end else if (accept && iLast) begin
      oSign  <= max_nxt.sign;
      oExp   <= max_nxt.exp;
      oFrac  <= max_nxt.frac;
      oIdx   <= idx_nxt;
      oCount <= cnt_nxt;
      oOvf   <= ovf_nxt;
    end
  end

endmodule
